psram_responder: RTL and testbench
==================================

PSRAM_RESPONDER -- requirements
Module: psram_responder

Interface
REQ-001 Parameter BANK, default 0, selects the chip enable to answer: 0 = cram_ce0_n, 1 = cram_ce1_n.
REQ-002 Parameter MEM_ADDR_WIDTH, default 10, sets the number of low word-address bits backed by storage; upper bits alias.
REQ-003 Parameter ACCESS_CYCLES, default 9, sets the minimum clock edges from first sampled adv_n low until read data is valid.
REQ-004 Parameter WRITE_PULSE_CYCLES, default 6, sets the minimum we_n-low cycles before the write-violation check passes.
REQ-005 clk  input  1  sole clock; all inputs are sampled on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 cram_a  input  6  address bits 21:16.
REQ-008 cram_dq  inout  16  address bits 15:0 during the adv phase; data otherwise.
REQ-009 cram_wait  output  1  tied 0 (async mode only).
REQ-010 cram_adv_n, cram_cre, cram_ce0_n, cram_ce1_n, cram_oe_n, cram_we_n, cram_ub_n, cram_lb_n  input  1 each  PSRAM controls.
REQ-011 write_violation  output  1  one-cycle pulse on a write shorter than WRITE_PULSE_CYCLES.
REQ-012 read_violation  output  1  one-cycle pulse on a read ended before data was valid.

Function
REQ-013 "Selected" SHALL mean the chosen ce_n is sampled low and cram_cre is low; cram_cre high SHALL be treated as not selected (no config-register support).
REQ-014 The FSM SHALL have states IDLE, ADDR, ACTIVE, WRITE and READ.
- IDLE -> ADDR when selected with adv_n low.
REQ-015 In ADDR, the responder SHALL capture {cram_a, cram_dq} every cycle that adv_n is low.
- The first sampled adv_n high SHALL freeze the captured word address and move to ACTIVE.
REQ-016 In ACTIVE, we_n low SHALL go to WRITE; oe_n low with we_n high SHALL go to READ.
REQ-017 Deselection in any state SHALL return the FSM to IDLE on the next edge, after any pending commit per REQ-019.
REQ-018 adv_n sampled low again while selected in ACTIVE, WRITE or READ SHALL restart ADDR.
REQ-019 Write data path:
- In WRITE, cram_dq and the ub_n/lb_n byte enables SHALL be captured every cycle.
- On the first cycle with we_n high, or on deselection, the last captured data SHALL be committed to memory with the captured byte enables (ub_n -> bits 15:8, lb_n -> bits 7:0).
- Both enables high SHALL commit nothing.
REQ-020 A counter SHALL be loaded to 1 on the edge that first samples adv_n low, increment each edge, and saturate at ACCESS_CYCLES.
REQ-021 cram_dq SHALL be driven only when all of the following hold: selected, state READ, oe_n low, we_n high, adv_n high. Otherwise it SHALL be high-Z.
- The responder SHALL never drive cram_dq in the same cycle it samples adv_n low.
REQ-022 Driven read value, registered:
- Once the counter has reached ACCESS_CYCLES: memory word at the latched address, with byte lanes whose enable is high driven as 8'h00.
- Before that: the pattern 16'hBAD0.
REQ-023 read_violation SHALL pulse when READ ends (deselect or oe_n high) while the counter < ACCESS_CYCLES.
REQ-024 write_violation SHALL pulse at commit if we_n was low fewer than WRITE_PULSE_CYCLES cycles.
REQ-025 Reads SHALL see the previous write to the same address with no extra gap after the write commit cycle.

Reset
REQ-026 While reset is high, the FSM SHALL go to IDLE and the counters and captured address SHALL clear.
- cram_dq SHALL be high-Z, cram_wait SHALL be 0, and both violation outputs SHALL be 0.
- Memory contents SHALL be preserved.
REQ-027 Reset asserted mid-write SHALL discard the uncommitted data; reset mid-read SHALL release cram_dq on the next edge.

Structure
REQ-028 A shared package psram_pkg SHALL hold:
- the FSM state enum;
- INVALID_READ_PATTERN (16'hBAD0);
- the default timing cycle counts shared with the controller.
REQ-029 Storage SHALL be a sub-module psram_resp_mem: single port, 2^MEM_ADDR_WIDTH x 16, per-byte write enables, registered read.

Verification
REQ-030 Write 0x1234 to address 0x012345 with both bytes enabled, then read it back with the controller at 133.12 MHz -> read returns 0x1234, no violation pulses.
REQ-031 Write 0xAAAA, then write 0x55FF with ub_n high -> read returns 0xAAFF.
REQ-032 Drive oe_n low 3 edges after adv_n low, then deselect at edge 5 -> cram_dq shows 0xBAD0 while driven, and read_violation pulses once.
REQ-033 Assert we_n low for 3 cycles -> write commits and write_violation pulses once.
REQ-034 Assert reset mid-write -> memory unchanged; assert reset mid-read -> cram_dq high-Z on the next edge.
REQ-035 BANK=1 with only cram_ce0_n low, or with cram_cre high -> no drive on cram_dq and no memory change.

Source files
------------

// File: rtl/psram_pkg.sv
// rtl/psram_pkg.sv - shared PSRAM state, timing defaults and read-data helpers
package psram_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACTIVE,
        ST_WRITE,
        ST_READ
    } psram_state_e;

    localparam logic [15:0] INVALID_READ_PATTERN   = 16'hBAD0;
    localparam int          DEF_ACCESS_CYCLES      = 9;
    localparam int          DEF_WRITE_PULSE_CYCLES = 6;
    localparam int          WORD_ADDR_WIDTH        = 22;

    // A disabled byte lane reads back as zero rather than stale memory.
    function automatic logic [15:0] mask_lanes(input logic [15:0] d, input logic ub_n,
                                               input logic lb_n);
        return {(ub_n ? 8'h00 : d[15:8]), (lb_n ? 8'h00 : d[7:0])};
    endfunction

endpackage

// File: rtl/psram_resp_mem.sv
// rtl/psram_resp_mem.sv - single-port word storage with byte enables and registered read
module psram_resp_mem #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [1:0]            be,
    input  logic [15:0]           wdata,
    output logic [15:0]           rdata
);

    logic [15:0] mem [0:(1 << ADDR_WIDTH)-1];

    // Write-first: a read in the commit cycle already returns the merged word.
    always_ff @(posedge clk) begin
        if (be[1]) mem[addr][15:8] <= wdata[15:8];
        if (be[0]) mem[addr][7:0]  <= wdata[7:0];
        rdata <= {(be[1] ? wdata[15:8] : mem[addr][15:8]),
                  (be[0] ? wdata[7:0]  : mem[addr][7:0])};
    end

endmodule

// File: rtl/psram_responder.sv
// rtl/psram_responder.sv - asynchronous-mode PSRAM device model answering one chip enable
module psram_responder
    import psram_pkg::*;
#(
    parameter int BANK               = 0,
    parameter int MEM_ADDR_WIDTH     = 10,
    parameter int ACCESS_CYCLES      = DEF_ACCESS_CYCLES,
    parameter int WRITE_PULSE_CYCLES = DEF_WRITE_PULSE_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  cram_a,
    inout  wire  [15:0] cram_dq,
    output logic        cram_wait,
    input  logic        cram_adv_n,
    input  logic        cram_cre,
    input  logic        cram_ce0_n,
    input  logic        cram_ce1_n,
    input  logic        cram_oe_n,
    input  logic        cram_we_n,
    input  logic        cram_ub_n,
    input  logic        cram_lb_n,
    output logic        write_violation,
    output logic        read_violation
);

    localparam logic [7:0] ACC = 8'(ACCESS_CYCLES);
    localparam logic [7:0] WPC = 8'(WRITE_PULSE_CYCLES);

    psram_state_e                state_q, state_d;
    logic                        sel;
    logic                        capture_addr, load_cnt, wr_start, wr_capture, commit, read_end;
    logic [WORD_ADDR_WIDTH-1:0]  addr_q;
    logic [7:0]                  cnt_q, cnt_d, wcnt_q;
    logic [15:0]                 wdata_q, dq_q, rdata;
    logic [1:0]                  wbe_n_q, mem_be;
    logic                        drive_q;
    logic                        unused_addr;

    assign sel         = ((BANK == 1) ? !cram_ce1_n : !cram_ce0_n) && !cram_cre;
    assign cram_wait   = 1'b0;
    assign cram_dq     = (drive_q && cram_adv_n) ? dq_q : 16'hzzzz;
    assign unused_addr = ^addr_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        capture_addr = 1'b0;
        load_cnt     = 1'b0;
        wr_start     = 1'b0;
        wr_capture   = 1'b0;
        commit       = 1'b0;
        read_end     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel && !cram_adv_n) begin
                    state_d      = ST_ADDR;
                    capture_addr = 1'b1;
                    load_cnt     = 1'b1;
                end
            end
            ST_ADDR: begin
                if (!sel)             state_d = ST_IDLE;
                else if (!cram_adv_n) capture_addr = 1'b1;
                else                  state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (!sel) begin
                    state_d = ST_IDLE;
                end else if (!cram_adv_n) begin
                    state_d      = ST_ADDR;
                    capture_addr = 1'b1;
                    load_cnt     = 1'b1;
                end else if (!cram_we_n) begin
                    state_d  = ST_WRITE;
                    wr_start = 1'b1;
                end else if (!cram_oe_n) begin
                    state_d = ST_READ;
                end
            end
            ST_WRITE: begin
                // Every way out of WRITE commits the last captured word.
                if (!sel) begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end else if (!cram_adv_n) begin
                    commit       = 1'b1;
                    state_d      = ST_ADDR;
                    capture_addr = 1'b1;
                    load_cnt     = 1'b1;
                end else if (cram_we_n) begin
                    commit  = 1'b1;
                    state_d = ST_ACTIVE;
                end else begin
                    wr_capture = 1'b1;
                end
            end
            ST_READ: begin
                if (!sel) begin
                    read_end = 1'b1;
                    state_d  = ST_IDLE;
                end else if (!cram_adv_n) begin
                    read_end     = 1'b1;
                    state_d      = ST_ADDR;
                    capture_addr = 1'b1;
                    load_cnt     = 1'b1;
                end else if (cram_oe_n || !cram_we_n) begin
                    read_end = 1'b1;
                    state_d  = ST_ACTIVE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (load_cnt)                              cnt_d = 8'd1;
        else if (state_q != ST_IDLE && cnt_q < ACC) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q          <= '0;
            cnt_q           <= '0;
            wcnt_q          <= '0;
            wdata_q         <= '0;
            wbe_n_q         <= 2'b11;
            dq_q            <= '0;
            drive_q         <= 1'b0;
            read_violation  <= 1'b0;
            write_violation <= 1'b0;
        end else begin
            if (capture_addr) addr_q <= {cram_a, cram_dq};
            cnt_q <= cnt_d;
            if (wr_start)                      wcnt_q <= 8'd1;
            else if (wr_capture && wcnt_q < WPC) wcnt_q <= wcnt_q + 8'd1;
            if (wr_start || wr_capture) begin
                wdata_q <= cram_dq;
                wbe_n_q <= {cram_ub_n, cram_lb_n};
            end
            dq_q            <= (cnt_d >= ACC) ? mask_lanes(rdata, cram_ub_n, cram_lb_n)
                                              : INVALID_READ_PATTERN;
            drive_q         <= (state_d == ST_READ);
            read_violation  <= read_end && (cnt_q < ACC);
            write_violation <= commit && (wcnt_q < WPC);
        end
    end

    assign mem_be = (commit && !reset) ? ~wbe_n_q : 2'b00;

    psram_resp_mem #(
        .ADDR_WIDTH(MEM_ADDR_WIDTH)
    ) u_mem (
        .clk  (clk),
        .addr (addr_q[MEM_ADDR_WIDTH-1:0]),
        .be   (mem_be),
        .wdata(wdata_q),
        .rdata(rdata)
    );

endmodule

// File: tb/tb_psram_responder.sv
// tb/tb_psram_responder.sv - scoreboard bench for psram_responder on two chip enables
module tb_psram_responder;

    localparam int K_DATA = 0;
    localparam int K_RV0  = 1;
    localparam int K_WV0  = 2;
    localparam int K_RV1  = 3;
    localparam int K_WV1  = 4;
    localparam logic [15:0] HIZ = 16'hFFFF;

    typedef struct {
        int          kind;
        logic [15:0] val;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  cram_a = '0;
    logic        adv_n = 1'b1, cre = 1'b0, ce0_n = 1'b1, ce1_n = 1'b1;
    logic        oe_n = 1'b1, we_n = 1'b1, ub_n = 1'b0, lb_n = 1'b0;
    logic [15:0] tb_dq = '0;
    logic        tb_dq_en = 1'b0;
    tri1  [15:0] dq0, dq1;
    logic        wait0, wait1, rv0, wv0, rv1, wv1;

    logic        tb_sample = 1'b0;
    logic        tb_bus = 1'b0;
    logic        tb_done = 1'b0;
    logic        done_chk = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;
    exp_t        exp_q[$];

    assign dq0 = tb_dq_en ? tb_dq : 16'hzzzz;
    assign dq1 = tb_dq_en ? tb_dq : 16'hzzzz;

    always #4 clk = ~clk;

    psram_responder #(.BANK(0)) u_dut0 (
        .clk(clk), .reset(reset), .cram_a(cram_a), .cram_dq(dq0), .cram_wait(wait0),
        .cram_adv_n(adv_n), .cram_cre(cre), .cram_ce0_n(ce0_n), .cram_ce1_n(ce1_n),
        .cram_oe_n(oe_n), .cram_we_n(we_n), .cram_ub_n(ub_n), .cram_lb_n(lb_n),
        .write_violation(wv0), .read_violation(rv0)
    );

    psram_responder #(.BANK(1)) u_dut1 (
        .clk(clk), .reset(reset), .cram_a(cram_a), .cram_dq(dq1), .cram_wait(wait1),
        .cram_adv_n(adv_n), .cram_cre(cre), .cram_ce0_n(ce0_n), .cram_ce1_n(ce1_n),
        .cram_oe_n(oe_n), .cram_we_n(we_n), .cram_ub_n(ub_n), .cram_lb_n(lb_n),
        .write_violation(wv1), .read_violation(rv1)
    );

    task automatic observe(input int kind, input logic [15:0] val);
        exp_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: actual kind=%0d value=%h, required none", kind, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val !== val) begin
                n_fail++;
                $display("FAIL %s: actual kind=%0d value=%h, required kind=%0d value=%h",
                         e.name, kind, val, e.kind, e.val);
            end
        end
    endtask

    always @(negedge clk) begin
        if (tb_sample) begin
            observe(K_DATA, tb_bus ? dq1 : dq0);
            n_tests++;
            if (wait0 !== 1'b0 || wait1 !== 1'b0) begin
                n_fail++;
                $display("FAIL cram_wait: actual %b%b, required 00", wait0, wait1);
            end
        end
        if (rv0) observe(K_RV0, 16'h1);
        if (wv0) observe(K_WV0, 16'h1);
        if (rv1) observe(K_RV1, 16'h1);
        if (wv1) observe(K_WV1, 16'h1);
        if (tb_done && !done_chk) begin
            done_chk = 1'b1;
            n_tests++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL pending_events: actual %0d left, required 0 (next %s)",
                         exp_q.size(), exp_q[0].name);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        tb_sample = 1'b0;
    endtask

    task automatic expect_dq(input logic [15:0] v, input string nm);
        exp_t e;
        e.kind = K_DATA; e.val = v; e.name = nm;
        exp_q.push_back(e);
        tb_sample = 1'b1;
    endtask

    task automatic expect_evt(input int kind, input string nm);
        exp_t e;
        e.kind = kind; e.val = 16'h1; e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic idle_bus();
        ce0_n = 1'b1; ce1_n = 1'b1; cre = 1'b0; adv_n = 1'b1;
        oe_n = 1'b1; we_n = 1'b1; ub_n = 1'b0; lb_n = 1'b0; tb_dq_en = 1'b0;
    endtask

    task automatic start_addr(input bit ce, input bit cre_v, input logic [21:0] addr);
        ce0_n = ce; ce1_n = !ce; cre = cre_v; adv_n = 1'b0;
        cram_a = addr[21:16]; tb_dq = addr[15:0]; tb_dq_en = 1'b1;
    endtask

    task automatic do_write(input bit ce, input bit cre_v, input logic [21:0] addr,
                            input logic [15:0] data, input logic ub, input logic lb,
                            input int n, input bit rb, input logic [15:0] rb_exp);
        tick(); start_addr(ce, cre_v, addr);
        tick(); adv_n = 1'b1;
        tick(); we_n = 1'b0; tb_dq = data; ub_n = ub; lb_n = lb;
        if (n < 6 && !cre_v) expect_evt(ce ? K_WV1 : K_WV0, "short_write_viol");
        repeat (n - 1) tick();
        tick(); we_n = 1'b1; tb_dq_en = 1'b0; ub_n = 1'b0; lb_n = 1'b0; oe_n = !rb;
        tick();
        if (rb) begin
            tick(); expect_dq(rb_exp, "read_right_after_commit");
        end
        idle_bus();
        tick();
    endtask

    task automatic do_read(input bit ce, input bit cre_v, input logic [21:0] addr,
                           input logic ub, input logic lb, input logic [15:0] exp_data,
                           input bit drives, input string nm);
        tick(); start_addr(ce, cre_v, addr); ub_n = ub; lb_n = lb;
        tick(); adv_n = 1'b1; tb_dq_en = 1'b0;
        tick(); oe_n = 1'b0;
        repeat (5) tick();
        tick(); expect_dq(drives ? 16'hBAD0 : HIZ, {nm, "_edge8"});
        tick(); expect_dq(drives ? exp_data : HIZ, {nm, "_edge9"});
        oe_n = 1'b1;
        tick(); expect_dq(HIZ, {nm, "_release"});
        idle_bus();
        tick();
    endtask

    initial begin
        idle_bus();
        repeat (3) tick();
        expect_dq(HIZ, "reset_hiz");
        tick(); reset = 1'b0;
        tick();

        do_write(0, 0, 22'h012345, 16'h1234, 0, 0, 6, 0, 16'h0);
        do_read(0, 0, 22'h012345, 0, 0, 16'h1234, 1, "rd_1234");
        do_read(0, 0, 22'h000345, 0, 0, 16'h1234, 1, "rd_alias");
        do_read(0, 0, 22'h012345, 1, 0, 16'h0034, 1, "rd_ub_masked");

        do_write(0, 0, 22'h000100, 16'hAAAA, 0, 0, 6, 0, 16'h0);
        do_write(0, 0, 22'h000100, 16'h55FF, 1, 0, 6, 0, 16'h0);
        do_read(0, 0, 22'h000100, 0, 0, 16'hAAFF, 1, "rd_byte_merge");
        do_write(0, 0, 22'h000100, 16'h0000, 1, 1, 6, 0, 16'h0);
        do_read(0, 0, 22'h000100, 0, 0, 16'hAAFF, 1, "rd_no_lane_write");

        do_write(0, 0, 22'h000077, 16'hC3A5, 0, 0, 6, 1, 16'hC3A5);

        do_write(0, 0, 22'h000200, 16'h5A5A, 0, 0, 3, 0, 16'h0);
        do_read(0, 0, 22'h000200, 0, 0, 16'h5A5A, 1, "rd_short_write");

        // Early deselect: oe_n sampled at edge 4, ce high sampled at edge 5.
        tick(); start_addr(0, 0, 22'h000100);
        tick(); adv_n = 1'b1; tb_dq_en = 1'b0;
        tick();
        tick(); oe_n = 1'b0;
        tick(); expect_dq(16'hBAD0, "early_read_bad0"); ce0_n = 1'b1;
        tick(); expect_dq(HIZ, "early_read_release"); expect_evt(K_RV0, "read_viol");
        idle_bus();
        tick();

        tick(); start_addr(0, 0, 22'h012345);
        tick(); adv_n = 1'b1;
        tick(); we_n = 1'b0; tb_dq = 16'hDEAD;
        repeat (3) tick();
        reset = 1'b1;
        tick(); idle_bus();
        tick(); reset = 1'b0;
        tick();
        do_read(0, 0, 22'h012345, 0, 0, 16'h1234, 1, "rd_after_reset_write");

        tick(); start_addr(0, 0, 22'h000077);
        tick(); adv_n = 1'b1; tb_dq_en = 1'b0;
        tick(); oe_n = 1'b0;
        tick();
        tick(); expect_dq(16'hBAD0, "reset_read_bad0"); reset = 1'b1;
        tick(); expect_dq(HIZ, "reset_read_release");
        reset = 1'b0; idle_bus();
        tick();

        tb_bus = 1'b1;
        do_write(1, 0, 22'h000055, 16'h0F0F, 0, 0, 6, 0, 16'h0);
        do_read(1, 0, 22'h000055, 0, 0, 16'h0F0F, 1, "bank1_rd");
        do_write(0, 0, 22'h000055, 16'h7777, 0, 0, 6, 0, 16'h0);
        do_write(1, 1, 22'h000055, 16'h8888, 0, 0, 6, 0, 16'h0);
        do_read(0, 0, 22'h000055, 0, 0, 16'h0, 0, "bank1_ce0_nodrive");
        do_read(1, 1, 22'h000055, 0, 0, 16'h0, 0, "bank1_cre_nodrive");
        do_read(1, 0, 22'h000055, 0, 0, 16'h0F0F, 1, "bank1_unchanged");

        tb_done = 1'b1;
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
